// File: rtl/simt_pkg.sv
// Shared definitions for the SIMT divergence/reconvergence stack.
// Default entry layout matches the top-level default parameters.
package simt_pkg;

  localparam logic [3:0] EXECUTE = 4'b0110;

  localparam int PC_W   = 8;
  localparam int MASK_W = 4;

  typedef struct packed {
    logic [PC_W-1:0]   else_pc;
    logic [MASK_W-1:0] outer_mask;
    logic [MASK_W-1:0] pending_mask;
    logic              second_route;
  } simt_stack_entry_t;

endpackage

// File: rtl/simt_stack_storage.sv
// LIFO register array with push, pop and top-of-stack rewrite.
// The top entry is only meaningful while depth is non-zero.
module simt_stack_storage
  import simt_pkg::*;
#(
  parameter int W     = $bits(simt_stack_entry_t),
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          top_wr,
  input  logic [W-1:0]  push_data,
  input  logic [W-1:0]  top_data,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign wr_idx  = AW'(depth);
  assign top_idx = AW'(depth - DW'(1));
  assign top     = (depth != '0) ? mem[top_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
    end else if (push) begin
      mem[wr_idx] <= push_data;
      depth       <= depth + DW'(1);
    end else if (pop) begin
      depth <= depth - DW'(1);
    end else if (top_wr) begin
      mem[top_idx] <= top_data;
    end
  end

endmodule

// File: rtl/simt_reconv_stack.sv
// Nested SIMT divergence stack: active mask, else-path redirect
// and sticky overflow/underflow/protocol error flags.
module simt_reconv_stack
  import simt_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int STACK_DEPTH           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [3:0]                       core_state,
  input  logic                             decoded_ssy,
  input  logic                             decoded_sync,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] decoded_immediate,
  input  logic [THREADS_PER_BLOCK-1:0]     taken_mask,
  output logic [THREADS_PER_BLOCK-1:0]     thread_mask,
  output logic                             redirect_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] redirect_pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             overflow,
  output logic                             underflow,
  output logic                             protocol_err
);

  localparam int PW = PROGRAM_MEM_ADDR_BITS;
  localparam int T  = THREADS_PER_BLOCK;
  localparam int DW = $clog2(STACK_DEPTH+1);

  // Same field order as simt_stack_entry_t, sized by this instance.
  typedef struct packed {
    logic [PW-1:0] else_pc;
    logic [T-1:0]  outer_mask;
    logic [T-1:0]  pending_mask;
    logic          second_route;
  } entry_t;

  logic   update, ssy_ev, sync_ev, conflict;
  logic   full, empty;
  logic   push, pop, top_wr;
  logic [T-1:0] eff, rest;
  entry_t push_e, top_e, top_new;

  assign update   = enable && (core_state == EXECUTE);
  assign ssy_ev   = update && decoded_ssy && !decoded_sync;
  assign sync_ev  = update && decoded_sync && !decoded_ssy;
  assign conflict = update && decoded_ssy && decoded_sync;

  assign full  = (depth == DW'(STACK_DEPTH));
  assign empty = (depth == '0);

  assign eff  = taken_mask & thread_mask;
  assign rest = thread_mask & ~eff;

  // When nobody takes the if-path the else path runs right away.
  assign push_e = '{else_pc:      decoded_immediate,
                    outer_mask:   thread_mask,
                    pending_mask: rest,
                    second_route: (rest != '0) && (eff != '0)};

  assign top_new = '{else_pc:      top_e.else_pc,
                     outer_mask:   top_e.outer_mask,
                     pending_mask: top_e.pending_mask,
                     second_route: 1'b0};

  assign push   = ssy_ev && !full;
  assign top_wr = sync_ev && !empty && top_e.second_route;
  assign pop    = sync_ev && !empty && !top_e.second_route;

  simt_stack_storage #(
    .W     ($bits(entry_t)),
    .DEPTH (STACK_DEPTH),
    .DW    (DW)
  ) u_storage (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .top_wr    (top_wr),
    .push_data (push_e),
    .top_data  (top_new),
    .top       (top_e),
    .depth     (depth)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      thread_mask    <= '1;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      if (conflict)
        protocol_err <= 1'b1;
      if (ssy_ev && full)
        overflow <= 1'b1;
      if (sync_ev && empty)
        underflow <= 1'b1;
      if (push) begin
        if (eff != '0) begin
          thread_mask <= eff;
        end else begin
          thread_mask    <= rest;
          redirect_valid <= 1'b1;
          redirect_pc    <= decoded_immediate;
        end
      end
      if (top_wr) begin
        thread_mask    <= top_e.pending_mask;
        redirect_valid <= 1'b1;
        redirect_pc    <= top_e.else_pc;
      end
      if (pop)
        thread_mask <= top_e.outer_mask;
    end
  end

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Directed bench for simt_reconv_stack with T=4, STACK_DEPTH=2.
// Each step drives one cycle of inputs and checks registered outputs.
module tb_simt_reconv_stack;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] core_state;
  logic       decoded_ssy;
  logic       decoded_sync;
  logic [7:0] decoded_immediate;
  logic [3:0] taken_mask;
  logic [3:0] thread_mask;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [1:0] depth;
  logic       overflow, underflow, protocol_err;

  int n_checks = 0;
  int n_fail   = 0;

  simt_reconv_stack #(
    .PROGRAM_MEM_ADDR_BITS (8),
    .THREADS_PER_BLOCK     (4),
    .STACK_DEPTH           (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .core_state        (core_state),
    .decoded_ssy       (decoded_ssy),
    .decoded_sync      (decoded_sync),
    .decoded_immediate (decoded_immediate),
    .taken_mask        (taken_mask),
    .thread_mask       (thread_mask),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .depth             (depth),
    .overflow          (overflow),
    .underflow         (underflow),
    .protocol_err      (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic ssy, input logic sync,
                      input logic [7:0] imm, input logic [3:0] tk);
    @(negedge clk);
    decoded_ssy       = ssy;
    decoded_sync      = sync;
    decoded_immediate = imm;
    taken_mask        = tk;
    @(posedge clk);
    #1;
    decoded_ssy  = 1'b0;
    decoded_sync = 1'b0;
  endtask

  task automatic expect_st(input string tag, input logic [3:0] m,
                           input logic [1:0] d, input logic rv);
    chk({tag, "_mask"}, 32'(thread_mask), 32'(m));
    chk({tag, "_depth"}, 32'(depth), 32'(d));
    chk({tag, "_rv"}, 32'(redirect_valid), 32'(rv));
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    core_state = 4'b0110;
    decoded_ssy = 1'b0;
    decoded_sync = 1'b0;
    decoded_immediate = '0;
    taken_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_st("reset", 4'b1111, 2'd0, 1'b0);
    chk("reset_pc", 32'(redirect_pc), 32'h0);
    chk("reset_flags", 32'({overflow, underflow, protocol_err}), 32'h0);

    // Simple if/else
    step(1, 0, 8'h20, 4'b0011);
    expect_st("ie_ssy", 4'b0011, 2'd1, 1'b0);
    step(0, 1, 8'h00, 4'b0000);
    expect_st("ie_sync1", 4'b1100, 2'd1, 1'b1);
    chk("ie_sync1_pc", 32'(redirect_pc), 32'h20);
    step(0, 1, 8'h00, 4'b0000);
    expect_st("ie_sync2", 4'b1111, 2'd0, 1'b0);

    // All taken, then none taken
    step(1, 0, 8'h10, 4'b1111);
    expect_st("all_ssy", 4'b1111, 2'd1, 1'b0);
    step(0, 1, 8'h00, 4'b0000);
    expect_st("all_sync", 4'b1111, 2'd0, 1'b0);
    step(1, 0, 8'h30, 4'b0000);
    expect_st("none_ssy", 4'b1111, 2'd1, 1'b1);
    chk("none_ssy_pc", 32'(redirect_pc), 32'h30);
    step(0, 1, 8'h00, 4'b0000);
    expect_st("none_sync", 4'b1111, 2'd0, 1'b0);

    // Nesting, back-to-back
    step(1, 0, 8'h40, 4'b0011);
    expect_st("n_ssy1", 4'b0011, 2'd1, 1'b0);
    step(1, 0, 8'h50, 4'b0001);
    expect_st("n_ssy2", 4'b0001, 2'd2, 1'b0);
    step(0, 1, 8'h00, 4'b0000);
    expect_st("n_sync1", 4'b0010, 2'd2, 1'b1);
    chk("n_sync1_pc", 32'(redirect_pc), 32'h50);
    step(0, 1, 8'h00, 4'b0000);
    expect_st("n_sync2", 4'b0011, 2'd1, 1'b0);
    chk("n_pc_hold", 32'(redirect_pc), 32'h50);
    step(0, 1, 8'h00, 4'b0000);
    expect_st("n_sync3", 4'b1100, 2'd1, 1'b1);
    chk("n_sync3_pc", 32'(redirect_pc), 32'h40);
    step(0, 1, 8'h00, 4'b0000);
    expect_st("n_sync4", 4'b1111, 2'd0, 1'b0);

    // Overflow
    step(1, 0, 8'h60, 4'b0011);
    step(1, 0, 8'h70, 4'b0001);
    expect_st("of_fill", 4'b0001, 2'd2, 1'b0);
    chk("of_pre", 32'(overflow), 32'h0);
    step(1, 0, 8'h80, 4'b1111);
    expect_st("of_ssy", 4'b0001, 2'd2, 1'b0);
    chk("of_flag", 32'(overflow), 32'h1);

    // Gating
    core_state = 4'b0101;
    step(0, 1, 8'h00, 4'b0000);
    expect_st("gate_state", 4'b0001, 2'd2, 1'b0);
    core_state = 4'b0110;
    enable = 1'b0;
    step(0, 1, 8'h00, 4'b0000);
    expect_st("gate_en", 4'b0001, 2'd2, 1'b0);
    enable = 1'b1;

    // Conflict
    step(1, 1, 8'h90, 4'b0011);
    expect_st("conf", 4'b0001, 2'd2, 1'b0);
    chk("conf_flag", 32'(protocol_err), 32'h1);
    chk("sticky_of", 32'(overflow), 32'h1);

    // Reset mid-nest
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_st("rst_mid", 4'b1111, 2'd0, 1'b0);
    chk("rst_mid_flags", 32'({overflow, underflow, protocol_err}), 32'h0);

    // Underflow
    step(0, 1, 8'h00, 4'b0000);
    expect_st("uf", 4'b1111, 2'd0, 1'b0);
    chk("uf_flag", 32'(underflow), 32'h1);
    step(1, 0, 8'hA0, 4'b0110);
    expect_st("uf_after", 4'b0110, 2'd1, 1'b0);
    chk("uf_sticky", 32'(underflow), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
